// File: rtl/spi_mem_arb_pkg.sv
// spi_mem_arb_pkg: shared types and constants for the SPI/host memory arbiter
package spi_mem_arb_pkg;
  typedef enum logic [1:0] {RSRC_NONE, RSRC_SPI, RSRC_HOST} rsrc_t;
  localparam int STAT_W = 32;
endpackage

// File: rtl/spi_mem_arb_stats.sv
// spi_mem_arb_stats: saturating SPI-grant, host-accept and host-stall counters (clk, rst, inc_* in, *_cnt out)
module spi_mem_arb_stats
  import spi_mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_spi,
  input  logic              inc_host,
  input  logic              inc_stall,
  output logic [STAT_W-1:0] spi_cnt,
  output logic [STAT_W-1:0] host_cnt,
  output logic [STAT_W-1:0] stall_cnt
);
  always_ff @(posedge clk) begin
    if (rst) begin
      spi_cnt   <= '0;
      host_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (inc_spi && !(&spi_cnt)) spi_cnt <= spi_cnt + 1'b1;
      if (inc_host && !(&host_cnt)) host_cnt <= host_cnt + 1'b1;
      if (inc_stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: SPI-priority arbiter sharing one byte memory with a valid/ready host port (s_* SPI, h_* host, m_* memory; stat_* outputs with SPI_MEM_ARB_STATS_EN)
module spi_mem_arbiter
  import spi_mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [23:0]       s_addr,
  input  logic              s_en,
  input  logic              s_wr,
  input  logic [DATA_W-1:0] s_wdata,
  output logic [DATA_W-1:0] s_rdata,
  input  logic              h_valid,
  output logic              h_ready,
  input  logic              h_wr,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  output logic              m_en,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
`ifdef SPI_MEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_spi_cnt,
  output logic [STAT_W-1:0] stat_host_cnt,
  output logic [STAT_W-1:0] stat_stall_cnt
`endif
);
  rsrc_t rsrc, rsrc_next;
  logic [DATA_W-1:0] s_hold, h_hold;
  logic unused_addr_hi;
  assign unused_addr_hi = ^s_addr[23:ADDR_W];
  assign h_ready = ~s_en;
  always_comb begin
    m_en      = s_en | h_valid;
    m_wr      = s_en ? s_wr : h_valid & h_wr;
    m_addr    = s_en ? s_addr[ADDR_W-1:0] : h_addr;
    m_wdata   = s_en ? s_wdata : h_wdata;
    rsrc_next = s_en ? RSRC_SPI : (h_valid && !h_wr) ? RSRC_HOST : RSRC_NONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rsrc   <= RSRC_NONE;
      s_hold <= '0;
      h_hold <= '0;
    end else begin
      rsrc <= rsrc_next;
      if (rsrc == RSRC_SPI) s_hold <= m_rdata;
      if (rsrc == RSRC_HOST) h_hold <= m_rdata;
    end
  end
  // rst gates the pulse so a read accepted just before reset never reports
  assign h_rvalid = (rsrc == RSRC_HOST) & ~rst;
  assign h_rdata  = h_rvalid ? m_rdata : h_hold;
  assign s_rdata  = (rsrc == RSRC_SPI) ? m_rdata : s_hold;
`ifdef SPI_MEM_ARB_STATS_EN
  spi_mem_arb_stats u_stats (
    .clk       (clk),
    .rst       (rst),
    .inc_spi   (s_en),
    .inc_host  (h_valid & ~s_en),
    .inc_stall (h_valid & s_en),
    .spi_cnt   (stat_spi_cnt),
    .host_cnt  (stat_host_cnt),
    .stall_cnt (stat_stall_cnt)
  );
`endif
endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb_spi_mem_arbiter: directed self-checking bench for spi_mem_arbiter with a behavioural byte memory
module tb_spi_mem_arbiter;
  logic clk = 0;
  logic rst = 1;
  logic [23:0] s_addr = '0;
  logic s_en = 0, s_wr = 0;
  logic [7:0] s_wdata = '0, s_rdata;
  logic h_valid = 0, h_ready, h_wr = 0, h_rvalid;
  logic [15:0] h_addr = '0;
  logic [7:0] h_wdata = '0, h_rdata;
  logic m_en, m_wr;
  logic [15:0] m_addr;
  logic [7:0] m_wdata, m_rdata = '0;
  logic [7:0] mem [0:65535];
  int total = 0, passed = 0;
`ifdef SPI_MEM_ARB_STATS_EN
  logic [31:0] stat_spi_cnt, stat_host_cnt, stat_stall_cnt;
`endif

  spi_mem_arbiter dut (
    .clk(clk), .rst(rst), .s_addr(s_addr), .s_en(s_en), .s_wr(s_wr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .h_valid(h_valid), .h_ready(h_ready), .h_wr(h_wr), .h_addr(h_addr),
    .h_wdata(h_wdata), .h_rvalid(h_rvalid), .h_rdata(h_rdata), .m_en(m_en), .m_wr(m_wr),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
`ifdef SPI_MEM_ARB_STATS_EN
    , .stat_spi_cnt(stat_spi_cnt), .stat_host_cnt(stat_host_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_en) begin
      m_rdata <= mem[m_addr];
      if (m_wr) mem[m_addr] <= m_wdata;
    end
  end

  task automatic host_write(input logic [15:0] a, input logic [7:0] d);
    h_valid = 1; h_wr = 1; h_addr = a; h_wdata = d;
    @(negedge clk);
    h_valid = 0; h_wr = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    #1;
    total++; if (h_rvalid !== 1'b0) $display("FAIL reset_h_rvalid got %b exp 0", h_rvalid); else passed++;
    total++; if (m_en !== 1'b0) $display("FAIL reset_m_en got %b exp 0", m_en); else passed++;
    total++; if (h_ready !== 1'b1) $display("FAIL reset_h_ready got %b exp 1", h_ready); else passed++;
    rst = 0;
    @(negedge clk);
    #1;
    total++; if (s_rdata !== 8'h00) $display("FAIL reset_s_rdata got %h exp 00", s_rdata); else passed++;
    total++; if (h_rdata !== 8'h00) $display("FAIL reset_h_rdata got %h exp 00", h_rdata); else passed++;
  endtask

  task automatic test_host_rw;
    @(negedge clk);
    h_valid = 1; h_wr = 1; h_addr = 16'h0200; h_wdata = 8'hA5;
    #1;
    total++; if (h_ready !== 1'b1) $display("FAIL hw_ready got %b exp 1", h_ready); else passed++;
    total++; if ({m_en, m_wr, m_addr, m_wdata} !== {2'b11, 16'h0200, 8'hA5})
      $display("FAIL hw_mem_port got %b%b %h %h exp 11 0200 a5", m_en, m_wr, m_addr, m_wdata); else passed++;
    @(negedge clk);
    h_wr = 0;
    #1;
    total++; if (h_ready !== 1'b1) $display("FAIL hr_ready got %b exp 1", h_ready); else passed++;
    total++; if (h_rvalid !== 1'b0) $display("FAIL hw_no_rvalid got %b exp 0", h_rvalid); else passed++;
    @(negedge clk);
    h_valid = 0;
    #1;
    total++; if (h_rvalid !== 1'b1) $display("FAIL hr_rvalid got %b exp 1", h_rvalid); else passed++;
    total++; if (h_rdata !== 8'hA5) $display("FAIL hr_rdata got %h exp a5", h_rdata); else passed++;
    @(negedge clk);
    #1;
    total++; if (h_rvalid !== 1'b0) $display("FAIL hr_rvalid_pulse got %b exp 0", h_rvalid); else passed++;
    total++; if (h_rdata !== 8'hA5) $display("FAIL hr_rdata_hold got %h exp a5", h_rdata); else passed++;
  endtask

  task automatic test_contention;
    host_write(16'h0400, 8'h4C);
    host_write(16'h0010, 8'h33);
    s_en = 1; s_wr = 0; s_addr = 24'h00_0400;
    h_valid = 1; h_wr = 0; h_addr = 16'h0010;
    #1;
    total++; if (m_addr !== 16'h0400) $display("FAIL cont_m_addr_spi got %h exp 0400", m_addr); else passed++;
    total++; if (h_ready !== 1'b0) $display("FAIL cont_h_ready got %b exp 0", h_ready); else passed++;
    @(negedge clk);
    s_en = 0;
    #1;
    total++; if (s_rdata !== 8'h4C) $display("FAIL cont_s_rdata got %h exp 4c", s_rdata); else passed++;
    total++; if (m_addr !== 16'h0010) $display("FAIL cont_m_addr_host got %h exp 0010", m_addr); else passed++;
    total++; if (h_ready !== 1'b1) $display("FAIL cont_h_ready_retry got %b exp 1", h_ready); else passed++;
    @(negedge clk);
    h_valid = 0;
    #1;
    total++; if (s_rdata !== 8'h4C) $display("FAIL cont_s_rdata_during got %h exp 4c", s_rdata); else passed++;
    total++; if ({h_rvalid, h_rdata} !== {1'b1, 8'h33}) $display("FAIL cont_h_rdata got %b %h exp 1 33", h_rvalid, h_rdata); else passed++;
    @(negedge clk);
    #1;
    total++; if (s_rdata !== 8'h4C) $display("FAIL cont_s_rdata_after got %h exp 4c", s_rdata); else passed++;
  endtask

  task automatic test_spi_wrap;
    host_write(16'hFFFC, 8'h77);
    s_en = 1; s_wr = 1; s_addr = 24'h01_FFFC; s_wdata = 8'h00;
    #1;
    total++; if ({m_wr, m_addr} !== {1'b1, 16'hFFFC}) $display("FAIL wrap_w_addr got %b %h exp 1 fffc", m_wr, m_addr); else passed++;
    @(negedge clk);
    s_wr = 0; s_addr = 24'h01_0005;
    #1;
    total++; if (mem[16'hFFFC] !== 8'h00) $display("FAIL wrap_mem got %h exp 00", mem[16'hFFFC]); else passed++;
    total++; if ({m_wr, m_addr} !== {1'b0, 16'h0005}) $display("FAIL wrap_r_addr got %b %h exp 0 0005", m_wr, m_addr); else passed++;
    @(negedge clk);
    s_en = 0;
  endtask

  task automatic test_rst_midread;
    h_valid = 1; h_wr = 0; h_addr = 16'h0200;
    #1;
    total++; if (h_ready !== 1'b1) $display("FAIL mid_ready got %b exp 1", h_ready); else passed++;
    @(negedge clk);
    h_valid = 0; rst = 1;
    #1;
    total++; if (h_rvalid !== 1'b0) $display("FAIL mid_rvalid got %b exp 0", h_rvalid); else passed++;
    @(negedge clk);
    rst = 0;
    #1;
    total++; if (h_rvalid !== 1'b0) $display("FAIL mid_rvalid_after got %b exp 0", h_rvalid); else passed++;
    total++; if (h_rdata !== 8'h00) $display("FAIL mid_h_hold got %h exp 00", h_rdata); else passed++;
    total++; if (s_rdata !== 8'h00) $display("FAIL mid_s_hold got %h exp 00", s_rdata); else passed++;
  endtask

  task automatic test_back_to_back;
    int i = 0, acc = 0, stall = 0, cyc = 0, bad = 0;
    bit pend = 1;
    rst = 1;
    @(negedge clk);
    rst = 0;
    while (i < 256 && cyc < 600) begin
      s_en = pend; s_wr = 0; s_addr = 24'h00_2000;
      h_valid = 1; h_wr = 1; h_addr = 16'h1000 + 16'(i); h_wdata = 8'(i) ^ 8'h5A;
      #1;
      if (s_en) pend = 0;
      if (h_ready) begin
        acc++; i++;
        if (i % 8 == 0) pend = 1;
      end else stall++;
      cyc++;
      @(negedge clk);
    end
    s_en = 0; h_valid = 0; h_wr = 0;
    total++; if (acc !== 256) $display("FAIL stream_accepted got %0d exp 256", acc); else passed++;
    total++; if (stall !== 32) $display("FAIL stream_stalls got %0d exp 32", stall); else passed++;
    for (int k = 0; k < 256; k++)
      if (mem[16'h1000 + 16'(k)] !== (8'(k) ^ 8'h5A)) bad++;
    total++; if (bad !== 0) $display("FAIL stream_mem got %0d bad bytes exp 0", bad); else passed++;
`ifdef SPI_MEM_ARB_STATS_EN
    #1;
    total++; if (stat_host_cnt !== 32'd256) $display("FAIL stat_host got %0d exp 256", stat_host_cnt); else passed++;
    total++; if (stat_spi_cnt !== 32'd32) $display("FAIL stat_spi got %0d exp 32", stat_spi_cnt); else passed++;
    total++; if (stat_stall_cnt !== 32'd32) $display("FAIL stat_stall got %0d exp 32", stat_stall_cnt); else passed++;
`endif
  endtask

`ifdef SPI_MEM_ARB_STATS_EN
  task automatic test_stats_saturate;
    force dut.u_stats.stall_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.u_stats.stall_cnt;
    s_en = 1; h_valid = 1; h_wr = 0;
    @(negedge clk);
    s_en = 0; h_valid = 0;
    #1;
    total++; if (stat_stall_cnt !== 32'hFFFF_FFFF) $display("FAIL stat_saturate got %h exp ffffffff", stat_stall_cnt); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_host_rw();
    test_contention();
    test_spi_wrap();
    test_rst_midread();
    test_back_to_back();
`ifdef SPI_MEM_ARB_STATS_EN
    test_stats_saturate();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/spi_mem_arbiter.md
Name: spi_mem_arbiter

Overview:
- Shares one synchronous single-port byte memory between two requesters: the spi_sram_slave memory port and a host/loader port (debug, preload, result readback).
- The SPI side cannot stall, so it has absolute priority; the host uses a valid/ready handshake and gets idle cycles only.
- Sits between spi_sram_slave and the memory array in SPI CPU benches and top levels.

Parameters:
- ADDR_W, 16, memory address width; SPI 24-bit address truncated to ADDR_W LSBs
- DATA_W, 8, data width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- s_addr  in  24  SPI slave memory address
- s_en  in  1  SPI slave access strobe, single cycle
- s_wr  in  1  SPI slave write (qualified by s_en)
- s_wdata  in  DATA_W  SPI slave write data
- s_rdata  out  DATA_W  SPI slave read data
- h_valid  in  1  host request valid
- h_ready  out  1  host request accepted this cycle when high with h_valid
- h_wr  in  1  host write
- h_addr  in  ADDR_W  host address
- h_wdata  in  DATA_W  host write data
- h_rvalid  out  1  one-cycle pulse, host read data valid
- h_rdata  out  DATA_W  host read data
- m_en, m_wr  out  1  memory strobe / write
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data, registered: valid the cycle after m_en (read-before-write on same-cycle write)

Behaviour:
- Clock/reset: single clk; rst synchronous, active-high.
- Grant (combinational): s_en=1 -> SPI owns the port: m_en=1, m_wr=s_wr, m_addr=s_addr[ADDR_W-1:0], m_wdata=s_wdata. Otherwise, if h_valid=1 -> host owns it with h_wr/h_addr/h_wdata. Otherwise m_en=0.
- h_ready = ~s_en. A host transfer completes in the same cycle as h_valid & h_ready. The host must hold its request stable until it is accepted.
- Read-source register rsrc, values {NONE, SPI, HOST}, updated every cycle:
  - SPI if SPI was granted (read or write; memory returns data either way).
  - HOST if a host read was accepted.
  - NONE otherwise.
- s_rdata:
  - Cycle after an SPI grant (rsrc==SPI): m_rdata passes through combinationally, and the same value is captured into s_hold.
  - All other cycles: s_rdata = s_hold.
  - s_rdata therefore stays stable while the host uses the memory.
- h_rvalid = (rsrc==HOST), exactly 1 cycle after acceptance. h_rdata = m_rdata that cycle and is captured into h_hold; it equals h_hold otherwise. No h_rvalid for host writes.
- Simultaneous s_en and h_valid: SPI wins, h_ready=0, the host retries next cycle. Back-to-back host accesses are allowed every cycle with no bubble.
- Reset values: rsrc=NONE, s_hold=0, h_hold=0, h_rvalid=0.
  - Combinational outputs follow their inputs during reset.
  - Reset mid-read suppresses the pending h_rvalid.
- Address wrap: s_addr bits above ADDR_W are ignored (0x01_0005 -> 0x0005).

Optional Feature:
- Macro: SPI_MEM_ARB_STATS_EN.
- When defined, adds outputs:
  - stat_spi_cnt [31:0]: counts SPI grants.
  - stat_host_cnt [31:0]: counts accepted host transfers.
  - stat_stall_cnt [31:0]: counts cycles with h_valid & ~h_ready.
- Counters are cleared by rst and saturate at 0xFFFF_FFFF.
- When undefined: ports and logic are absent, with identical functional behaviour otherwise.

Decomposition:
- Package spi_mem_arb_pkg:
  - typedef enum logic [1:0] rsrc_t {RSRC_NONE, RSRC_SPI, RSRC_HOST}
  - STAT_W=32 constant
- Sub-module spi_mem_arb_stats (saturating counter triple), instantiated only under SPI_MEM_ARB_STATS_EN.

Test Plan:
- Host write 0xA5 to 0x0200, then host read 0x0200 -> h_ready=1 both cycles; h_rvalid pulses 1 cycle after the read; h_rdata=0xA5 and held afterwards.
- s_en read of 0x00_0400 (mem=0x4C) on the same cycle as h_valid read of 0x0010 -> m_addr=0x0400, h_ready=0. Next cycle: s_rdata=0x4C, host granted, m_addr=0x0010. s_rdata remains 0x4C during the host read and after.
- SPI write s_addr=0x01_FFFC data 0x00 -> memory 0xFFFC written; s_addr MSBs ignored.
- Host streams 256 writes every cycle while s_en pulses every 8th cycle -> exactly 256 accepted, 32 stall cycles, memory contents correct.
- rst asserted the cycle after a host read is accepted -> h_rvalid stays 0; s_hold and h_hold read 0.
- With SPI_MEM_ARB_STATS_EN, replaying the streaming test -> stat_host_cnt=256, stat_spi_cnt=32, stat_stall_cnt=32. Forcing stat_stall_cnt to 0xFFFF_FFFF and stalling once -> it stays at 0xFFFF_FFFF.
